// File: rtl/time_set_control_pkg.sv
// Shared constants for the front-panel path: mode encodings, digit positions,
// digit wrap limits, and the wrap-increment helper used when editing digits.
package time_set_control_pkg;

    typedef enum logic [1:0] {
        NORMAL_MODE    = 2'b00,
        CLOCK_SET_MODE = 2'b01,
        ALARM_SET_MODE = 2'b10
    } mode_t;

    localparam logic [2:0] POS_NONE   = 3'd0;
    localparam logic [2:0] POS_HOUR_T = 3'd1;
    localparam logic [2:0] POS_HOUR_O = 3'd2;
    localparam logic [2:0] POS_MIN_T  = 3'd3;
    localparam logic [2:0] POS_MIN_O  = 3'd4;
    localparam logic [2:0] POS_SEC_T  = 3'd5;
    localparam logic [2:0] POS_SEC_O  = 3'd6;

    localparam logic [3:0] HOUR_T_MAX    = 4'd2;
    localparam logic [3:0] HOUR_O_MAX    = 4'd9;
    localparam logic [3:0] HOUR_O_MAX_20 = 4'd3;
    localparam logic [3:0] TENS_MAX      = 4'd5;
    localparam logic [3:0] ONES_MAX      = 4'd9;

    // >= rather than == so an out-of-range captured digit still wraps to 0
    function automatic logic [3:0] inc_wrap(input logic [3:0] v, input logic [3:0] max);
        return (v >= max) ? 4'd0 : v + 4'd1;
    endfunction

endpackage

// File: rtl/time_set_control_button_debounce.sv
// One button: 2-FF synchronizer, stability counter, one-cycle press pulse on
// an accepted 0->1 change. Press appears 2 + DEBOUNCE_CYCLES cycles after a clean edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/time_set_control.sv
// Front-panel controller: debounced buttons drive the mode FSM, digit
// selection and digit editing; clock edits are pushed out with time_load.
module time_set_control
    import time_set_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_shift,
    input  logic       btn_inc,
    input  logic [3:0] cur_sec_ones,
    input  logic [2:0] cur_sec_tens,
    input  logic [3:0] cur_min_ones,
    input  logic [2:0] cur_min_tens,
    input  logic [3:0] cur_hour_ones,
    input  logic [1:0] cur_hour_tens,
    output logic [1:0] mode,
    output logic [2:0] pos,
    output logic       clock_hold,
    output logic       time_load,
    output logic [3:0] set_sec_ones,
    output logic [2:0] set_sec_tens,
    output logic [3:0] set_min_ones,
    output logic [2:0] set_min_tens,
    output logic [3:0] set_hour_ones,
    output logic [1:0] set_hour_tens,
    output logic [1:0] alarm_hour_tens,
    output logic [3:0] alarm_hour_ones,
    output logic [2:0] alarm_minute_tens,
    output logic [3:0] alarm_minute_ones
);

    logic mode_p, shift_p, inc_p;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .press(mode_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_shift (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_shift), .press(shift_p));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc), .press(inc_p));

    mode_t      mode_q, mode_d;
    logic [2:0] pos_q, pos_d;
    logic       hold_q, hold_d, load_q, load_d;
    logic [1:0] s_ht_q, s_ht_d, a_ht_q, a_ht_d;
    logic [3:0] s_ho_q, s_ho_d, a_ho_q, a_ho_d;
    logic [2:0] s_mt_q, s_mt_d, a_mt_q, a_mt_d;
    logic [3:0] s_mo_q, s_mo_d, a_mo_q, a_mo_d;
    logic [2:0] s_st_q, s_st_d;
    logic [3:0] s_so_q, s_so_d;
    logic       edit_en;
    logic [3:0] e_ht, e_ho, e_mt, e_mo, e_st, e_so;

    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        hold_d  = hold_q;
        load_d  = 1'b0;
        s_ht_d  = s_ht_q;  s_ho_d = s_ho_q;  s_mt_d = s_mt_q;
        s_mo_d  = s_mo_q;  s_st_d = s_st_q;  s_so_d = s_so_q;
        a_ht_d  = a_ht_q;  a_ho_d = a_ho_q;  a_mt_d = a_mt_q;  a_mo_d = a_mo_q;
        edit_en = 1'b0;

        // Priority mode > shift > inc falls out of the if/else chains below
        case (mode_q)
            NORMAL_MODE: begin
                if (mode_p) begin
                    mode_d = CLOCK_SET_MODE;
                    pos_d  = POS_HOUR_T;
                    hold_d = 1'b1;
                    s_ht_d = cur_hour_tens;  s_ho_d = cur_hour_ones;
                    s_mt_d = cur_min_tens;   s_mo_d = cur_min_ones;
                    s_st_d = cur_sec_tens;   s_so_d = cur_sec_ones;
                end
            end
            CLOCK_SET_MODE: begin
                if (mode_p) begin
                    mode_d = ALARM_SET_MODE;
                    pos_d  = POS_HOUR_T;
                    hold_d = 1'b0;
                end else if (shift_p) begin
                    pos_d = (pos_q >= POS_SEC_O) ? POS_HOUR_T : pos_q + 3'd1;
                end else if (inc_p) begin
                    edit_en = 1'b1;
                end
            end
            ALARM_SET_MODE: begin
                if (mode_p) begin
                    mode_d = NORMAL_MODE;
                    pos_d  = POS_NONE;
                    hold_d = 1'b0;
                end else if (shift_p) begin
                    pos_d = (pos_q >= POS_MIN_O) ? POS_HOUR_T : pos_q + 3'd1;
                end else if (inc_p) begin
                    edit_en = 1'b1;
                end
            end
            default: begin
                mode_d = NORMAL_MODE;
                pos_d  = POS_NONE;
                hold_d = 1'b0;
            end
        endcase

        // Alarm and clock share one editor; hour/minute positions coincide
        if (mode_q == ALARM_SET_MODE) begin
            e_ht = {2'b0, a_ht_q}; e_ho = a_ho_q; e_mt = {1'b0, a_mt_q}; e_mo = a_mo_q;
        end else begin
            e_ht = {2'b0, s_ht_q}; e_ho = s_ho_q; e_mt = {1'b0, s_mt_q}; e_mo = s_mo_q;
        end
        e_st = {1'b0, s_st_q};
        e_so = s_so_q;

        if (edit_en) begin
            case (pos_q)
                POS_HOUR_T: begin
                    e_ht = inc_wrap(e_ht, HOUR_T_MAX);
                    if (e_ht == HOUR_T_MAX && e_ho > HOUR_O_MAX_20)
                        e_ho = HOUR_O_MAX_20;
                end
                POS_HOUR_O: e_ho = inc_wrap(e_ho, (e_ht == HOUR_T_MAX) ? HOUR_O_MAX_20 : HOUR_O_MAX);
                POS_MIN_T:  e_mt = inc_wrap(e_mt, TENS_MAX);
                POS_MIN_O:  e_mo = inc_wrap(e_mo, ONES_MAX);
                POS_SEC_T:  e_st = inc_wrap(e_st, TENS_MAX);
                POS_SEC_O:  e_so = inc_wrap(e_so, ONES_MAX);
                default: ;
            endcase

            if (mode_q == ALARM_SET_MODE) begin
                a_ht_d = e_ht[1:0]; a_ho_d = e_ho; a_mt_d = e_mt[2:0]; a_mo_d = e_mo;
            end else begin
                s_ht_d = e_ht[1:0]; s_ho_d = e_ho; s_mt_d = e_mt[2:0]; s_mo_d = e_mo;
                s_st_d = e_st[2:0]; s_so_d = e_so;
                load_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= NORMAL_MODE;
            pos_q  <= POS_NONE;
            hold_q <= 1'b0;
            load_q <= 1'b0;
            s_ht_q <= '0; s_ho_q <= '0; s_mt_q <= '0;
            s_mo_q <= '0; s_st_q <= '0; s_so_q <= '0;
            a_ht_q <= '0; a_ho_q <= '0; a_mt_q <= '0; a_mo_q <= '0;
        end else begin
            mode_q <= mode_d;
            pos_q  <= pos_d;
            hold_q <= hold_d;
            load_q <= load_d;
            s_ht_q <= s_ht_d; s_ho_q <= s_ho_d; s_mt_q <= s_mt_d;
            s_mo_q <= s_mo_d; s_st_q <= s_st_d; s_so_q <= s_so_d;
            a_ht_q <= a_ht_d; a_ho_q <= a_ho_d; a_mt_q <= a_mt_d; a_mo_q <= a_mo_d;
        end
    end

    assign mode              = mode_q;
    assign pos               = pos_q;
    assign clock_hold        = hold_q;
    assign time_load         = load_q;
    assign set_hour_tens     = s_ht_q;
    assign set_hour_ones     = s_ho_q;
    assign set_min_tens      = s_mt_q;
    assign set_min_ones      = s_mo_q;
    assign set_sec_tens      = s_st_q;
    assign set_sec_ones      = s_so_q;
    assign alarm_hour_tens   = a_ht_q;
    assign alarm_hour_ones   = a_ho_q;
    assign alarm_minute_tens = a_mt_q;
    assign alarm_minute_ones = a_mo_q;

endmodule
